// File: rtl/spi_pkg.sv
// spi_pkg: shared types, word width and counter sizing for the SPI data engine
package spi_pkg;
   localparam int W_CPU = 32;
   typedef enum logic {IDLE, SHIFT} spi_state_t;
   typedef enum logic {TX, RX} spi_dir_t;
   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction
endpackage

// File: rtl/spi_mosi_miso_if.sv
// spi_mosi_miso_if: word-level transmit/receive bus between the register file and the SPI engine
interface spi_mosi_miso_if #(parameter int WIDTH = 32);
   logic             transmit_ready;
   logic [WIDTH-1:0] transmit_data;
   logic             transmit_start;
   logic             mosi_out;
   logic             receive_ready;
   logic [WIDTH-1:0] receive_data;
   logic             receive_start;
   logic             miso_in;
   modport master (
      input  transmit_ready, mosi_out, receive_ready, receive_data,
      output transmit_data, transmit_start, receive_start, miso_in
   );
   modport slave (
      output transmit_ready, mosi_out, receive_ready, receive_data,
      input  transmit_data, transmit_start, receive_start, miso_in
   );
endinterface

// File: rtl/spi_shift_channel.sv
// spi_shift_channel: one IDLE/SHIFT channel; TX serializes a word MSB first, RX assembles one
module spi_shift_channel import spi_pkg::*; #(
   parameter int       WIDTH = W_CPU,
   parameter spi_dir_t DIR   = TX
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_start,
   input  logic [(DIR == TX ? WIDTH : 1)-1:0]     i_in,
   output logic                                   o_ready,
   output logic [(DIR == TX ? 1 : WIDTH)-1:0]     o_out
);
   localparam int CW = cnt_w(WIDTH);
   spi_state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic w_last, w_accept;
   assign w_last   = r_cnt == CW'(WIDTH - 1);
   assign w_accept = r_state == IDLE && i_start;
   assign o_ready  = r_state == IDLE;
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == IDLE) ? (i_start ? SHIFT : IDLE) : (w_last ? IDLE : SHIFT);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_state == SHIFT) ? r_cnt + 1'b1 : '0;
      end
   end
   generate
      if (DIR == TX) begin : g_tx
         // zeros shift in behind the word, so mosi returns to 0 once the last bit leaves
         logic [WIDTH-1:0] r_sh;
         always_ff @(posedge clk) begin
            if (rst) r_sh <= '0;
            else if (w_accept) r_sh <= i_in;
            else if (r_state == SHIFT) r_sh <= {r_sh[WIDTH-2:0], 1'b0};
         end
         assign o_out = r_sh[WIDTH-1];
      end else begin : g_rx
         // only WIDTH-1 bits are held; the final sample goes straight into the output word
         logic [WIDTH-2:0] r_sh;
         logic [WIDTH-1:0] r_word, w_word;
         assign w_word = {r_sh, i_in};
         always_ff @(posedge clk) begin
            if (rst) begin
               r_sh   <= '0;
               r_word <= '0;
            end else if (r_state == SHIFT) begin
               r_sh <= w_word[WIDTH-2:0];
               if (w_last) r_word <= w_word;
            end
         end
         assign o_out = r_word;
      end
   endgenerate
endmodule

// File: rtl/spi_mosi_miso.sv
// spi_mosi_miso: full-duplex word-serial SPI data engine (independent TX and RX channels)
// SPI_DEBUG_EN adds a per-cycle trace with a 32-bit mosi history; behaviour is unchanged.
module spi_mosi_miso import spi_pkg::*; #(
   parameter int WIDTH = W_CPU
) (
   input logic             clk,
   input logic             rst,
   spi_mosi_miso_if.slave  bus
);
   spi_shift_channel #(.WIDTH(WIDTH), .DIR(TX)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_start (bus.transmit_start),
      .i_in    (bus.transmit_data),
      .o_ready (bus.transmit_ready),
      .o_out   (bus.mosi_out)
   );
   spi_shift_channel #(.WIDTH(WIDTH), .DIR(RX)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .i_start (bus.receive_start),
      .i_in    (bus.miso_in),
      .o_ready (bus.receive_ready),
      .o_out   (bus.receive_data)
   );
`ifdef SPI_DEBUG_EN
   logic [31:0] r_hist;
   always_ff @(posedge clk) begin
      if (rst) r_hist <= '0;
      else r_hist <= {r_hist[30:0], bus.mosi_out};
      $display("spi: txr=%b txs=%b mosi=%b hist=%h rxr=%b rxs=%b miso=%b rxd=%h",
               bus.transmit_ready, bus.transmit_start, bus.mosi_out, r_hist,
               bus.receive_ready, bus.receive_start, bus.miso_in, bus.receive_data);
   end
`else
`endif
endmodule

// File: tb/tb_spi_mosi_miso.sv
// tb_spi_mosi_miso: directed scoreboard bench for the SPI data engine
module tb_spi_mosi_miso;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lp = 1'b0;
   logic miso_drv = 1'b0;
   int total = 0;
   int bad = 0;
   logic bq[$];
   logic [31:0] wq[$];
   logic [31:0] exp_rd = '0;
   logic [31:0] cap;
   spi_mosi_miso_if #(.WIDTH(32)) bus();
   assign bus.miso_in = lp ? bus.mosi_out : miso_drv;
   spi_mosi_miso #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic xfer(input logic do_tx, input logic do_rx, input logic inj,
                       input logic [31:0] txd, input logic [31:0] rxd);
      int n;
      bus.transmit_data  = txd;
      bus.transmit_start = do_tx;
      bus.receive_start  = do_rx;
      step();
      bus.transmit_start = 1'b0;
      bus.receive_start  = 1'b0;
      bus.transmit_data  = '0;
      if (do_tx) for (int k = 31; k >= 0; k--) bq.push_back(txd[k]);
      if (do_rx) wq.push_back(rxd);
      cap = '0;
      for (int k = 0; k < 32; k++) begin
         miso_drv = rxd[31-k];
         if (do_tx) begin
            cap = {cap[30:0], bus.mosi_out};
            chk("tx_bit", {31'b0, bus.mosi_out}, {31'b0, bq.pop_front()});
            chk("tx_busy", {31'b0, bus.transmit_ready}, 32'd0);
         end
         if (do_rx) begin
            chk("rx_busy", {31'b0, bus.receive_ready}, 32'd0);
            chk("rx_hold", bus.receive_data, exp_rd);
         end
         bus.transmit_start = inj && k == 10;
         bus.transmit_data  = {32{inj && k == 10}};
         step();
      end
      bus.transmit_start = 1'b0;
      bus.transmit_data  = '0;
      if (do_tx) begin
         chk("tx_capture", cap, txd);
         chk("tx_gap_bit", {31'b0, bus.mosi_out}, 32'd0);
         chk("tx_ready", {31'b0, bus.transmit_ready}, 32'd1);
      end
      if (do_rx) begin
         n = 0;
         while (!bus.receive_ready && n < 8) begin
            step();
            n++;
         end
         chk("rx_ready", {31'b0, bus.receive_ready}, 32'd1);
         chk("rx_latency_extra", n, 32'd0);
         exp_rd = wq.pop_front();
         chk("rx_word", bus.receive_data, exp_rd);
      end
   endtask
   initial begin
      bus.transmit_data  = '0;
      bus.transmit_start = 1'b0;
      bus.receive_start  = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_tx_ready", {31'b0, bus.transmit_ready}, 32'd1);
      chk("rst_rx_ready", {31'b0, bus.receive_ready}, 32'd1);
      chk("rst_mosi", {31'b0, bus.mosi_out}, 32'd0);
      chk("rst_rx_data", bus.receive_data, 32'd0);
      xfer(1'b1, 1'b0, 1'b0, 32'hA5C3_0F81, 32'h0);
      xfer(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
      xfer(1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0);
      repeat (3) begin
         step();
         chk("no_second_word_mosi", {31'b0, bus.mosi_out}, 32'd0);
         chk("no_second_word_ready", {31'b0, bus.transmit_ready}, 32'd1);
      end
      lp = 1'b1;
      xfer(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678);
      lp = 1'b0;
      xfer(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
      xfer(1'b1, 1'b0, 1'b0, 32'h8000_0001, 32'h0);
      bus.transmit_data  = 32'hFFFF_FFFF;
      bus.transmit_start = 1'b1;
      bus.receive_start  = 1'b1;
      miso_drv = 1'b1;
      step();
      bus.transmit_start = 1'b0;
      bus.receive_start  = 1'b0;
      repeat (5) step();
      chk("mid_tx_busy", {31'b0, bus.transmit_ready}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_tx_ready", {31'b0, bus.transmit_ready}, 32'd1);
      chk("abort_rx_ready", {31'b0, bus.receive_ready}, 32'd1);
      chk("abort_mosi", {31'b0, bus.mosi_out}, 32'd0);
      chk("abort_rx_data", bus.receive_data, 32'd0);
      step();
      chk("abort_mosi_stays", {31'b0, bus.mosi_out}, 32'd0);
      chk("abort_rx_data_stays", bus.receive_data, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
